// File: rtl/kyber_keygen_loader.sv
// rtl/kyber_keygen_loader.sv - Baby-Kyber keygen sequencer: streams coefficients in, triggers keygen, streams public key out
// Drives the accelerator's memory-mapped window with registered kt_* outputs; single outstanding read.
module kyber_keygen_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_7000,
  parameter logic [31:0] TRIG_ADDR = 32'h4000_7164,
  parameter int          N_IN      = 32,
  parameter int          N_OUT     = 24,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        kt_enable,
  output logic        kt_key_enable,
  output logic        kt_wen,
  output logic [31:0] kt_addr,
  output logic [31:0] kt_data,
  output logic [7:0]  kt_bytelane,
  input  logic [31:0] kt_data_resp,
  input  logic        kt_key_done
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [5:0]    LAST_IN  = 6'(N_IN - 1);
  localparam logic [4:0]    LAST_OUT = 5'(N_OUT - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, TRIG, WAIT, RD_ADDR, RD_WAIT, OUT
  } state_t;

  state_t        state;
  logic [5:0]    idx;
  logic [4:0]    k;
  logic [4:0]    k_nxt;
  logic [TW-1:0] timer;
  logic          key_done_q;
  logic [31:0]   wr_addr;
  logic [31:0]   rd_next_addr;

  assign in_ready     = (state == LOAD);
  assign busy         = (state != IDLE);
  assign kt_bytelane  = 8'hFF;
  assign k_nxt        = k + 5'd1;
  assign wr_addr      = BASE_ADDR + {24'd0, idx, 2'b00};
  assign rd_next_addr = BASE_ADDR + {25'd0, k_nxt, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      k             <= '0;
      timer         <= '0;
      key_done_q    <= 1'b0;
      error         <= 1'b0;
      done          <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      kt_enable     <= 1'b0;
      kt_key_enable <= 1'b0;
      kt_wen        <= 1'b0;
      kt_addr       <= '0;
      kt_data       <= '0;
    end else begin
      done       <= 1'b0;
      kt_wen     <= 1'b0;
      key_done_q <= kt_key_done;
      case (state)
        IDLE: begin
          kt_addr <= '0;
          kt_data <= '0;
          if (start) begin
            state         <= LOAD;
            error         <= 1'b0;
            idx           <= '0;
            k             <= '0;
            timer         <= '0;
            kt_enable     <= 1'b1;
            kt_key_enable <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            kt_wen  <= 1'b1;
            kt_addr <= wr_addr;
            kt_data <= in_data;
            idx     <= idx + 6'd1;
            if (idx == LAST_IN) state <= TRIG;
          end
        end
        TRIG: begin
          kt_wen  <= 1'b1;
          kt_addr <= TRIG_ADDR;
          kt_data <= '0;
          timer   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          kt_addr <= '0;
          kt_data <= '0;
          // Edge-qualified so a key_done left high by a previous run cannot fire early.
          if (kt_key_done && !key_done_q) begin
            state   <= RD_ADDR;
            k       <= '0;
            kt_addr <= BASE_ADDR;
          end else if (timer == T_LAST) begin
            error         <= 1'b1;
            state         <= IDLE;
            kt_enable     <= 1'b0;
            kt_key_enable <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RD_ADDR: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Accelerator has registered the response for the address held since RD_ADDR.
          out_data  <= kt_data_resp;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == LAST_OUT) begin
              done          <= 1'b1;
              state         <= IDLE;
              kt_enable     <= 1'b0;
              kt_key_enable <= 1'b0;
              kt_addr       <= '0;
            end else begin
              k       <= k_nxt;
              kt_addr <= rd_next_addr;
              state   <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_keygen_loader.sv
// tb/tb_kyber_keygen_loader.sv - directed bench for kyber_keygen_loader with an accelerator model
module tb_kyber_keygen_loader;

  localparam logic [31:0] BASE = 32'h4000_7000;
  localparam logic [31:0] TRIG = 32'h4000_7164;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, error;
  logic        kt_enable, kt_key_enable, kt_wen;
  logic [31:0] kt_addr, kt_data;
  logic [7:0]  kt_bytelane;
  logic [31:0] resp = '0;
  logic        kd = 1'b0;

  kyber_keygen_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error),
    .kt_enable(kt_enable), .kt_key_enable(kt_key_enable), .kt_wen(kt_wen),
    .kt_addr(kt_addr), .kt_data(kt_data), .kt_bytelane(kt_bytelane),
    .kt_data_resp(resp), .kt_key_done(kd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Accelerator model: registered read data, key_done drops then rises ~10 cycles after the trigger.
  bit kd_never = 1'b0;
  int kd_cnt = 0;
  always @(posedge clk) begin
    if (!kt_wen && kt_addr >= BASE && kt_addr < BASE + 32'd96)
      resp <= 32'h100 + ((kt_addr - BASE) >> 2);
    else
      resp <= 32'hDEAD_BEEF;
    if (kt_wen && kt_addr == TRIG) kd_cnt <= 1;
    else if (kd_cnt != 0 && kd_cnt < 20) kd_cnt <= kd_cnt + 1;
    else kd_cnt <= 0;
    if (kd_cnt == 4) kd <= 1'b0;
    if (kd_cnt == 9 && !kd_never) kd <= 1'b1;
  end

  logic acc_q = 1'b0;
  always @(posedge clk) acc_q <= in_valid && in_ready && rst_n;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] oq[$];
  int  done_cnt = 0, first_out = -1, rise_cyc = -1, err_cyc = -1, trig_cyc = -1;
  logic kd_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (kt_wen) begin
      wa.push_back(kt_addr);
      wd.push_back(kt_data);
      if (kt_addr == TRIG) trig_cyc = cyc;
    end
    if (out_valid && out_ready) oq.push_back(out_data);
    if (out_valid && first_out < 0) first_out = cyc;
    if (done) done_cnt++;
    if (kd && !kd_prev) rise_cyc = cyc;
    kd_prev = kd;
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
    if (busy || acc_q) chk1("write_follows_accept", kt_wen && kt_addr != TRIG, acc_q);
  end

  task automatic do_run(input bit tog, input int stall_w, input bit never, input bit exp_ok);
    int w, budget, stall;
    wa.delete(); wd.delete(); oq.delete();
    done_cnt = 0; first_out = -1; rise_cyc = -1; err_cyc = -1; trig_cyc = -1;
    kd_never = never;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("start_clears_error", error, 1'b0);
    chk1("busy_after_start", busy, 1'b1);
    w = 0; budget = 0;
    while (w < 32 && budget < 500) begin
      in_valid = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = tog ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 32'(w + 1);
      if (in_valid && in_ready) w++;
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    in_valid = tog;
    chk("words_loaded", 32'(w), 32'd32);
    stall = 0; budget = 0;
    while (done_cnt == 0 && !error && budget < 3000) begin
      if (out_valid && oq.size() == stall_w && stall < 7) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (!out_ready) begin
        chk("stall_data", out_data, 32'h100 + 32'(stall_w));
        chk("stall_addr", kt_addr, BASE + 32'(4 * stall_w));
        chk1("stall_valid", out_valid, 1'b1);
      end
      @(posedge clk); #1;
      budget++;
    end
    chk1("run_finished_in_budget", budget < 3000, 1'b1);
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("busy_end", busy, 1'b0);
    chk("n_writes", 32'(wa.size()), 32'd33);
    for (int i = 0; i < 32 && i < wa.size(); i++) begin
      chk("wr_addr", wa[i], BASE + 32'(4 * i));
      chk("wr_data", wd[i], 32'(i + 1));
    end
    if (wa.size() >= 33) begin
      chk("trig_addr", wa[32], TRIG);
      chk("trig_data", wd[32], 32'd0);
    end
    if (exp_ok) begin
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk1("error_clear", error, 1'b0);
      chk("n_out", 32'(oq.size()), 32'd24);
      for (int i = 0; i < oq.size(); i++) chk("out_word", oq[i], 32'h100 + 32'(i));
      chk("keydone_to_out_latency", 32'(first_out - rise_cyc), 32'd3);
      if (stall_w >= 0) chk("stall_cycles", 32'(stall), 32'd7);
    end else begin
      chk("done_pulses", 32'(done_cnt), 32'd0);
      chk1("error_set", error, 1'b1);
      chk("n_out", 32'(oq.size()), 32'd0);
      chk("timeout_cycles", 32'(err_cyc - trig_cyc), 32'd1024);
    end
  endtask

  typedef struct {
    bit tog;
    int stall_w;
    bit never;
    bit exp_ok;
  } case_t;

  case_t cases[4];

  initial begin
    int nw;
    cases[0] = '{tog: 1'b0, stall_w: -1, never: 1'b0, exp_ok: 1'b1};
    cases[1] = '{tog: 1'b1, stall_w:  5, never: 1'b0, exp_ok: 1'b1};
    cases[2] = '{tog: 1'b0, stall_w: -1, never: 1'b1, exp_ok: 1'b0};
    cases[3] = '{tog: 1'b1, stall_w: -1, never: 1'b0, exp_ok: 1'b1};

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_error", error, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'd0);
      chk1("rst_kt_enable", kt_enable, 1'b0);
      chk1("rst_kt_key_enable", kt_key_enable, 1'b0);
      chk1("rst_kt_wen", kt_wen, 1'b0);
      chk("rst_kt_addr", kt_addr, 32'd0);
      chk("rst_kt_data", kt_data, 32'd0);
      chk("rst_bytelane", {24'd0, kt_bytelane}, 32'hFF);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    for (int c = 0; c < 4; c++) do_run(cases[c].tog, cases[c].stall_w, cases[c].never, cases[c].exp_ok);

    // Abort mid-LOAD after 10 words, then a clean run must restart at BASE.
    wa.delete(); wd.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 10; w++) begin
      in_valid = 1'b1;
      in_data  = 32'(w + 1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    nw = wa.size();
    chk("abort_writes_before_reset", 32'(nw), 32'd10);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b0);
    chk1("abort_kt_enable", kt_enable, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_more_writes", 32'(wa.size()), 32'(nw));
    chk1("abort_idle", busy, 1'b0);
    do_run(1'b0, -1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
